// File: rtl/arm_decode_pkg.sv
// arm_decode_pkg: shared types and encodings for the registered ARM decode stage.
//   - DP opcode and condition-code constants
//   - multiply mode codes (same encoding the multiplier consumes)
//   - uop_class enum, cin_sel / logic_idx / shifter encodings
//   - packed micro-op struct stored in the output buffer
//   - condition evaluation helper
package arm_decode_pkg;

    // Data-processing opcodes, instr[24:21]
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    // Condition codes, instr[31:28]
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Multiply modes, instr[23:21]; 010/011 are undefined
    localparam logic [2:0] MUL_MUL   = 3'b000;
    localparam logic [2:0] MUL_MLA   = 3'b001;
    localparam logic [2:0] MUL_UMULL = 3'b100;
    localparam logic [2:0] MUL_UMLAL = 3'b101;
    localparam logic [2:0] MUL_SMULL = 3'b110;
    localparam logic [2:0] MUL_SMLAL = 3'b111;

    typedef enum logic [1:0] {
        UOP_DP    = 2'd0,
        UOP_MUL   = 2'd1,
        UOP_NOP   = 2'd2,
        UOP_UNDEF = 2'd3
    } uop_class_t;

    localparam logic [1:0] CIN_ZERO  = 2'd0;
    localparam logic [1:0] CIN_ONE   = 2'd1;
    localparam logic [1:0] CIN_C     = 2'd2;
    localparam logic [1:0] CIN_NOT_C = 2'd3;

    localparam logic [2:0] LOGIC_AND = 3'd0;
    localparam logic [2:0] LOGIC_ORR = 3'd1;
    localparam logic [2:0] LOGIC_EOR = 3'd2;

    localparam logic [2:0] SHMODE_ROR_IMM = 3'b100;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HI   = 1'b1
    } fsm_state_t;

    // Register indices are held at their native 4-bit width; the top zero-extends.
    typedef struct packed {
        uop_class_t  uop_class;
        logic [3:0]  alu_op;
        logic        inv_a;
        logic        inv_b;
        logic        is_logic;
        logic [2:0]  logic_idx;
        logic [1:0]  cin_sel;
        logic        pass_b;
        logic        reg_w;
        logic        s_on;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic        is_immediate;
        logic [7:0]  imm8;
        logic [3:0]  rot4;
        logic [2:0]  shifter_mode;
        logic [4:0]  shifter_count;
        logic        reg_shift;
        logic [2:0]  mul_mode;
        logic        accumulate;
        logic        uop_last;
        logic        cond_fail;
    } uop_t;

    // nzcv = {N, Z, C, V}; AL and NV both report pass here (NV is trapped by the caller)
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        logic pass;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/arm_decode_stage_if.sv
// arm_decode_stage_if: instruction-in / micro-op-out handshake bundle.
//   Input side : in_valid, in_ready, in_instr[31:0], flags_nzcv[3:0]
//   Output side: out_valid, out_ready and the decoded head-of-buffer fields
//   modport slave  : the decode stage
//   modport master : the producer/consumer environment
interface arm_decode_stage_if #(
    parameter int REG_AW = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [3:0]        flags_nzcv;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        uop_class;
    logic [3:0]        alu_op;
    logic              inv_a;
    logic              inv_b;
    logic              is_logic;
    logic [2:0]        logic_idx;
    logic [1:0]        cin_sel;
    logic              pass_b;
    logic              reg_w;
    logic              s_on;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rm;
    logic [REG_AW-1:0] rs;
    logic              is_immediate;
    logic [7:0]        imm8;
    logic [3:0]        rot4;
    logic [2:0]        shifter_mode;
    logic [4:0]        shifter_count;
    logic              reg_shift;
    logic [2:0]        mul_mode;
    logic              accumulate;
    logic              uop_last;
    logic              cond_fail;

    modport slave (
        input  in_valid, in_instr, flags_nzcv, out_ready,
        output in_ready, out_valid, uop_class, alu_op, inv_a, inv_b, is_logic,
               logic_idx, cin_sel, pass_b, reg_w, s_on, rd, rn, rm, rs,
               is_immediate, imm8, rot4, shifter_mode, shifter_count, reg_shift,
               mul_mode, accumulate, uop_last, cond_fail
    );

    modport master (
        output in_valid, in_instr, flags_nzcv, out_ready,
        input  in_ready, out_valid, uop_class, alu_op, inv_a, inv_b, is_logic,
               logic_idx, cin_sel, pass_b, reg_w, s_on, rd, rn, rm, rs,
               is_immediate, imm8, rot4, shifter_mode, shifter_count, reg_shift,
               mul_mode, accumulate, uop_last, cond_fail
    );
endinterface

// File: rtl/arm_uop_fifo.sv
// arm_uop_fifo: DEPTH-entry synchronous FIFO of uop_t micro-ops.
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data  : write request and micro-op (ignored when full)
//   i_pop           : remove head (ignored when empty)
//   o_data          : head entry (meaningful only when o_count != 0)
//   o_count         : number of stored entries, 0..DEPTH
module arm_uop_fifo
    import arm_decode_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  uop_t          i_data,
    input  logic          i_pop,
    output uop_t          o_data,
    output logic [CW-1:0] o_count
);
    uop_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && (r_count != CW'(DEPTH));
    assign w_pop   = i_pop && (r_count != {CW{1'b0}});
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Entry storage; contents need no reset because the head is qualified by count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1'b1);
                2'b01:   r_count <= r_count - CW'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/arm_decode_stage.sv
// arm_decode_stage: registered, handshaked ARM data-processing / multiply decoder.
//   clk, rst : clock, synchronous active-high reset
//   bus      : arm_decode_stage_if.slave
//              in_valid/in_ready/in_instr/flags_nzcv  instruction input
//              out_valid/out_ready + decoded fields   micro-op buffer head
// Long multiplies expand into two micro-ops (RdLo then RdHi); the second is
// issued from the HI state so the input is stalled for that cycle.
// Optional feature macro: ARM_DECODE_COND_EXEC_EN (condition evaluation).
// Without it every instruction is treated as AL and cond_fail stays 0.
module arm_decode_stage
    import arm_decode_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int REG_AW = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input logic              clk,
    input logic              rst,
    arm_decode_stage_if.slave bus
);
    fsm_state_t    r_state;
    uop_t          r_hi_uop;
    logic          r_run;
    uop_t          w_uop0;
    uop_t          w_uop1;
    logic          w_long;
    uop_t          w_push_data;
    logic          w_push;
    logic          w_pop;
    logic          w_room;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_out_valid;
    uop_t          w_fifo_head;
    uop_t          w_head;
    logic [CW-1:0] w_count;
    logic [31:0]   w_instr;
    logic          w_cond_ok;
    logic          w_cond_undef;
    logic          w_is_mul;
    logic          w_is_dp;
    logic          w_mul_bad;

    assign w_instr = bus.in_instr;

`ifdef ARM_DECODE_COND_EXEC_EN
    assign w_cond_undef = (w_instr[31:28] == COND_NV);
    assign w_cond_ok    = cond_pass(w_instr[31:28], bus.flags_nzcv);
`else
    logic w_unused_cond;
    assign w_unused_cond = ^{bus.flags_nzcv, w_instr[31:28]};
    assign w_cond_undef  = 1'b0;
    assign w_cond_ok     = 1'b1;
`endif

    assign w_is_mul  = (w_instr[27:24] == 4'h0) && (w_instr[7:4] == 4'b1001);
    assign w_is_dp   = !w_is_mul && (w_instr[27:26] == 2'b00);
    assign w_mul_bad = w_is_mul && (w_instr[23:22] == 2'b01);

    // in_ready depends only on registers; r_run keeps it low through reset
    assign w_room      = (w_count < CW'(DEPTH));
    assign w_in_ready  = r_run && (r_state == ST_IDLE) && w_room;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_out_valid = (w_count != {CW{1'b0}});
    assign w_pop       = w_out_valid && bus.out_ready;

    // Decode the offered instruction into its first (and, for long multiplies, second) micro-op
    always_comb begin
        w_uop0 = '0;
        w_uop1 = '0;
        w_long = 1'b0;
        if (w_cond_undef) begin
            w_uop0.uop_class = UOP_UNDEF;
            w_uop0.uop_last  = 1'b1;
        end else if (!w_cond_ok) begin
            // A failed long multiply collapses to this single NOP
            w_uop0.uop_class = UOP_NOP;
            w_uop0.cond_fail = 1'b1;
            w_uop0.uop_last  = 1'b1;
        end else if (w_is_mul && !w_mul_bad) begin
            w_uop0.uop_class  = UOP_MUL;
            w_uop0.mul_mode   = w_instr[23:21];
            w_uop0.accumulate = w_instr[21];
            w_uop0.rm         = w_instr[3:0];
            w_uop0.rs         = w_instr[11:8];
            w_uop0.reg_w      = 1'b1;
            if (w_instr[23]) begin
                w_long          = 1'b1;
                w_uop1          = w_uop0;
                w_uop0.rd       = w_instr[15:12];
                w_uop0.rn       = w_instr[15:12];
                w_uop0.uop_last = 1'b0;
                w_uop0.s_on     = 1'b0;
                w_uop1.rd       = w_instr[19:16];
                w_uop1.rn       = w_instr[19:16];
                w_uop1.uop_last = 1'b1;
                w_uop1.s_on     = w_instr[20];
            end else begin
                w_uop0.rd       = w_instr[19:16];
                w_uop0.rn       = w_instr[15:12];
                w_uop0.s_on     = w_instr[20];
                w_uop0.uop_last = 1'b1;
            end
        end else if (w_is_dp) begin
            w_uop0.uop_class = UOP_DP;
            w_uop0.alu_op    = w_instr[24:21];
            w_uop0.rd        = w_instr[15:12];
            w_uop0.rn        = w_instr[19:16];
            w_uop0.reg_w     = 1'b1;
            w_uop0.s_on      = w_instr[20];
            w_uop0.uop_last  = 1'b1;
            if (w_instr[25]) begin
                w_uop0.is_immediate  = 1'b1;
                w_uop0.imm8          = w_instr[7:0];
                w_uop0.rot4          = w_instr[11:8];
                w_uop0.shifter_mode  = SHMODE_ROR_IMM;
                w_uop0.shifter_count = {w_instr[11:8], 1'b0};
            end else begin
                w_uop0.rm           = w_instr[3:0];
                w_uop0.reg_shift    = w_instr[4];
                w_uop0.shifter_mode = {1'b0, w_instr[6:5]};
                if (w_instr[4]) begin
                    w_uop0.rs            = w_instr[11:8];
                    w_uop0.shifter_count = 5'd0;
                end else begin
                    w_uop0.shifter_count = w_instr[11:7];
                end
            end
            case (w_instr[24:21])
                OP_AND: begin w_uop0.is_logic = 1'b1; w_uop0.logic_idx = LOGIC_AND; end
                OP_EOR: begin w_uop0.is_logic = 1'b1; w_uop0.logic_idx = LOGIC_EOR; end
                OP_SUB: begin w_uop0.inv_b = 1'b1; w_uop0.cin_sel = CIN_ONE; end
                OP_RSB: begin w_uop0.inv_a = 1'b1; w_uop0.cin_sel = CIN_ONE; end
                OP_ADD: w_uop0.cin_sel = CIN_ZERO;
                OP_ADC: w_uop0.cin_sel = CIN_C;
                OP_SBC: begin w_uop0.inv_b = 1'b1; w_uop0.cin_sel = CIN_C; end
                OP_RSC: begin w_uop0.inv_a = 1'b1; w_uop0.cin_sel = CIN_C; end
                OP_TST: begin w_uop0.is_logic = 1'b1; w_uop0.logic_idx = LOGIC_AND; end
                OP_TEQ: begin w_uop0.is_logic = 1'b1; w_uop0.logic_idx = LOGIC_EOR; end
                OP_CMP: begin w_uop0.inv_b = 1'b1; w_uop0.cin_sel = CIN_ONE; end
                OP_CMN: w_uop0.cin_sel = CIN_ZERO;
                OP_ORR: begin w_uop0.is_logic = 1'b1; w_uop0.logic_idx = LOGIC_ORR; end
                OP_MOV: w_uop0.pass_b = 1'b1;
                OP_BIC: begin
                    w_uop0.is_logic  = 1'b1;
                    w_uop0.logic_idx = LOGIC_AND;
                    w_uop0.inv_b     = 1'b1;
                end
                OP_MVN: begin w_uop0.pass_b = 1'b1; w_uop0.inv_b = 1'b1; end
                default: w_uop0.cin_sel = CIN_ZERO;
            endcase
            // Compare/test ops only update flags
            if (w_instr[24:23] == 2'b10) begin
                w_uop0.reg_w = 1'b0;
                w_uop0.s_on  = 1'b1;
            end else begin
                w_uop0.reg_w = 1'b1;
            end
        end else begin
            w_uop0.uop_class = UOP_UNDEF;
            w_uop0.uop_last  = 1'b1;
        end
    end

    // Select what enters the buffer: the stashed RdHi micro-op in HI, else the fresh decode
    always_comb begin
        if (r_state == ST_HI) begin
            w_push      = w_room;
            w_push_data = r_hi_uop;
        end else begin
            w_push      = w_accept;
            w_push_data = w_uop0;
        end
    end

    // Long-multiply sequencer; reset drops any pending RdHi micro-op
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_hi_uop <= '0;
            r_run    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_long) begin
                        r_hi_uop <= w_uop1;
                        r_state  <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (w_room) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    arm_uop_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_count (w_count)
    );

    // Head fields read as zero while the buffer is empty
    always_comb begin
        if (w_out_valid) begin
            w_head = w_fifo_head;
        end else begin
            w_head = '0;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = w_out_valid;
    assign bus.uop_class     = w_head.uop_class;
    assign bus.alu_op        = w_head.alu_op;
    assign bus.inv_a         = w_head.inv_a;
    assign bus.inv_b         = w_head.inv_b;
    assign bus.is_logic      = w_head.is_logic;
    assign bus.logic_idx     = w_head.logic_idx;
    assign bus.cin_sel       = w_head.cin_sel;
    assign bus.pass_b        = w_head.pass_b;
    assign bus.reg_w         = w_head.reg_w;
    assign bus.s_on          = w_head.s_on;
    assign bus.rd            = REG_AW'(w_head.rd);
    assign bus.rn            = REG_AW'(w_head.rn);
    assign bus.rm            = REG_AW'(w_head.rm);
    assign bus.rs            = REG_AW'(w_head.rs);
    assign bus.is_immediate  = w_head.is_immediate;
    assign bus.imm8          = w_head.imm8;
    assign bus.rot4          = w_head.rot4;
    assign bus.shifter_mode  = w_head.shifter_mode;
    assign bus.shifter_count = w_head.shifter_count;
    assign bus.reg_shift     = w_head.reg_shift;
    assign bus.mul_mode      = w_head.mul_mode;
    assign bus.accumulate    = w_head.accumulate;
    assign bus.uop_last      = w_head.uop_last;
    assign bus.cond_fail     = w_head.cond_fail;
endmodule
